// File: rtl/rice_bus_arbiter_pkg.sv
// Shared types for the two-requester bus arbiter.
package rice_bus_arbiter_pkg;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } rice_bus_requester_id;

  localparam int unsigned REQUESTER_COUNT = 2;

  // The requester that is not 'id'; used to hand priority over after a grant.
  function automatic rice_bus_requester_id other_id(input rice_bus_requester_id id);
    return (id == INST) ? DATA : INST;
  endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Valid/ready request + response bus used by core ports and memory.
interface rice_bus_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8;

  logic                     request_valid;
  logic                     request_ready;
  logic [ADDRESS_WIDTH-1:0] request_address;
  logic                     request_write;
  logic [DATA_WIDTH-1:0]    request_write_data;
  logic [STROBE_WIDTH-1:0]  request_strobe;
  logic                     response_valid;
  logic                     response_ready;
  logic [DATA_WIDTH-1:0]    response_read_data;
  logic                     response_error;

  // Requester side: drives requests, consumes responses.
  modport master (
    output request_valid,
    input  request_ready,
    output request_address,
    output request_write,
    output request_write_data,
    output request_strobe,
    input  response_valid,
    output response_ready,
    input  response_read_data,
    input  response_error
  );

  // Completer side: consumes requests, produces responses.
  modport slave (
    input  request_valid,
    output request_ready,
    input  request_address,
    input  request_write,
    input  request_write_data,
    input  request_strobe,
    output response_valid,
    input  response_ready,
    output response_read_data,
    output response_error
  );

endinterface

// File: rtl/rice_bus_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for requests awaiting a response.
// Synchronous, no bypass: a push while full is dropped, a pop while empty is ignored.
module rice_bus_arbiter_id_fifo
  import rice_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 push_i,
  input  rice_bus_requester_id push_id_i,
  input  logic                 pop_i,
  output rice_bus_requester_id head_id_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]    count_q, count_d;
  rice_bus_requester_id mem_q [DEPTH];
  rice_bus_requester_id mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  // Explicit wrap keeps non-power-of-two depths correct as well.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Flags, guarded handshakes and next-state for pointers, count and storage.
  always_comb begin
    full_o    = (count_q == CountW'(DEPTH));
    empty_o   = (count_q == '0);
    head_id_o = mem_q[rd_ptr_q];
    do_push   = push_i & ~full_o;
    do_pop    = pop_i & ~empty_o;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage needs no reset; entries are only read when the count says valid.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rice_bus_arbiter.sv
// Round-robin arbiter merging instruction and data buses onto one memory bus.
// Requests pass through combinationally; responses return in order, steered by
// the ID FIFO head.
module rice_bus_arbiter
  import rice_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  rice_bus_if.slave  inst_bus_if,
  rice_bus_if.slave  data_bus_if,
  rice_bus_if.master memory_bus_if
);

  localparam int unsigned StrobeW = DATA_WIDTH / 8;

  // Arbitration state.
  rice_bus_requester_id prio_q, prio_d;
  rice_bus_requester_id lock_id_q, lock_id_d;
  logic                 lock_q, lock_d;

  // Combinational arbitration results.
  logic [REQUESTER_COUNT-1:0] req_valid_vec;
  rice_bus_requester_id       grant;
  logic                       granted_valid;
  logic                       mem_req_valid;
  logic                       granted_ready;
  logic                       accept;

  // Muxed request payload.
  logic [ADDRESS_WIDTH-1:0] mux_address;
  logic                     mux_write;
  logic [DATA_WIDTH-1:0]    mux_write_data;
  logic [StrobeW-1:0]       mux_strobe;

  // Response routing.
  rice_bus_requester_id head_id;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 rsp_route;
  logic                 mem_rsp_ready;
  logic                 pop;

  // Grant selection: a stalled request keeps its grant, otherwise round-robin.
  always_comb begin
    req_valid_vec = {data_bus_if.request_valid, inst_bus_if.request_valid};
    if (lock_q) begin
      grant = lock_id_q;
    end else if (&req_valid_vec) begin
      grant = prio_q;
    end else if (req_valid_vec[DATA]) begin
      grant = DATA;
    end else if (req_valid_vec[INST]) begin
      grant = INST;
    end else begin
      grant = prio_q;
    end

    granted_valid = req_valid_vec[grant];
    // A full ID FIFO blocks issue even if a pop happens this cycle.
    mem_req_valid = i_rst_n & granted_valid & ~fifo_full;
    granted_ready = i_rst_n & memory_bus_if.request_ready & ~fifo_full;
    accept        = mem_req_valid & memory_bus_if.request_ready;
  end

  // Request payload mux from the granted requester.
  always_comb begin
    if (grant == DATA) begin
      mux_address    = data_bus_if.request_address;
      mux_write      = data_bus_if.request_write;
      mux_write_data = data_bus_if.request_write_data;
      mux_strobe     = data_bus_if.request_strobe;
    end else begin
      mux_address    = inst_bus_if.request_address;
      mux_write      = inst_bus_if.request_write;
      mux_write_data = inst_bus_if.request_write_data;
      mux_strobe     = inst_bus_if.request_strobe;
    end
  end

  // Response steering to the requester at the FIFO head.
  always_comb begin
    rsp_route     = i_rst_n & ~fifo_empty;
    mem_rsp_ready = rsp_route & ((head_id == DATA) ? data_bus_if.response_ready
                                                   : inst_bus_if.response_ready);
    pop           = memory_bus_if.response_valid & mem_rsp_ready;
  end

  // Next-state: hand priority over on acceptance, lock grant while stalled.
  always_comb begin
    prio_d    = accept ? other_id(grant) : prio_q;
    lock_d    = mem_req_valid & ~memory_bus_if.request_ready;
    lock_id_d = lock_d ? grant : lock_id_q;
  end

  // Arbitration registers; priority resets to the data requester.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prio_q    <= DATA;
      lock_q    <= 1'b0;
      lock_id_q <= INST;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  rice_bus_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push_i    (accept),
    .push_id_i (grant),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Downstream request.
  assign memory_bus_if.request_valid      = mem_req_valid;
  assign memory_bus_if.request_address    = mux_address;
  assign memory_bus_if.request_write      = mux_write;
  assign memory_bus_if.request_write_data = mux_write_data;
  assign memory_bus_if.request_strobe     = mux_strobe;
  assign memory_bus_if.response_ready     = mem_rsp_ready;

  // Upstream handshakes.
  assign inst_bus_if.request_ready  = granted_ready & (grant == INST);
  assign data_bus_if.request_ready  = granted_ready & (grant == DATA);
  assign inst_bus_if.response_valid = memory_bus_if.response_valid & rsp_route &
                                      (head_id == INST);
  assign data_bus_if.response_valid = memory_bus_if.response_valid & rsp_route &
                                      (head_id == DATA);

  // Response payload is shared; only the valid is steered.
  assign inst_bus_if.response_read_data = memory_bus_if.response_read_data;
  assign inst_bus_if.response_error     = memory_bus_if.response_error;
  assign data_bus_if.response_read_data = memory_bus_if.response_read_data;
  assign data_bus_if.response_error     = memory_bus_if.response_error;

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed bench for rice_bus_arbiter with a 1-cycle memory model and a response
// scoreboard keyed on requester ID.
module tb_rice_bus_arbiter;
  import rice_bus_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rice_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) inst_if ();
  rice_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) data_if ();
  rice_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  rice_bus_arbiter #(
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .inst_bus_if   (inst_if),
    .data_bus_if   (data_if),
    .memory_bus_if (mem_if)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mem_pend[$];
  int          checks = 0;
  int          errors = 0;
  logic        mem_rsp_en = 1'b0;
  logic        stray = 1'b0;

  function automatic logic [31:0] rsp_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_AAAA;
    if (a == 32'h200) return 32'h0000_BBBB;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the memory response from the model, let the DUT settle.
  task automatic settle();
    if (stray) begin
      mem_if.response_valid     = 1'b1;
      mem_if.response_read_data = 32'hDEAD_BEEF;
    end else if (mem_rsp_en && mem_pend.size() != 0) begin
      mem_if.response_valid     = 1'b1;
      mem_if.response_read_data = rsp_of(mem_pend[0]);
    end else begin
      mem_if.response_valid     = 1'b0;
      mem_if.response_read_data = '0;
    end
    mem_if.response_error = 1'b0;
    #1;
    chk("rsp_onehot", inst_if.response_valid & data_if.response_valid, 0);
  endtask

  // Record handshakes of this cycle, then move past the next rising edge.
  task automatic advance();
    sb_t e;
    if ((inst_if.response_valid && inst_if.response_ready) ||
        (data_if.response_valid && data_if.response_ready)) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", data_if.response_valid, e.id);
        chk("rsp_data", data_if.response_valid ? data_if.response_read_data
                                               : inst_if.response_read_data, e.data);
      end
    end
    if (inst_if.request_valid && inst_if.request_ready)
      sb.push_back('{id: 1'b0, data: rsp_of(inst_if.request_address)});
    if (data_if.request_valid && data_if.request_ready)
      sb.push_back('{id: 1'b1, data: rsp_of(data_if.request_address)});
    if (!stray && mem_if.response_valid && mem_if.response_ready)
      void'(mem_pend.pop_front());
    if (mem_if.request_valid && mem_if.request_ready)
      mem_pend.push_back(mem_if.request_address);
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drain();
    inst_if.request_valid  = 1'b0;
    data_if.request_valid  = 1'b0;
    inst_if.response_ready = 1'b1;
    data_if.response_ready = 1'b1;
    mem_rsp_en             = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    inst_if.request_valid      = 1'b0;
    inst_if.request_address    = '0;
    inst_if.request_write      = 1'b0;
    inst_if.request_write_data = '0;
    inst_if.request_strobe     = '0;
    inst_if.response_ready     = 1'b1;
    data_if.request_valid      = 1'b0;
    data_if.request_address    = '0;
    data_if.request_write      = 1'b0;
    data_if.request_write_data = '0;
    data_if.request_strobe     = '1;
    data_if.response_ready     = 1'b1;
    mem_if.request_ready       = 1'b1;
    mem_if.response_valid      = 1'b0;
    mem_if.response_read_data  = '0;
    mem_if.response_error      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs quiet in reset even with traffic on every side.
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'h1000;
    data_if.request_valid   = 1'b1;
    data_if.request_address = 32'h2000;
    stray = 1'b1;
    settle();
    chk("rst_inst_req_ready", inst_if.request_ready, 0);
    chk("rst_data_req_ready", data_if.request_ready, 0);
    chk("rst_mem_req_valid", mem_if.request_valid, 0);
    chk("rst_mem_rsp_ready", mem_if.response_ready, 0);
    chk("rst_inst_rsp_valid", inst_if.response_valid, 0);
    chk("rst_data_rsp_valid", data_if.response_valid, 0);
    advance();
    stray = 1'b0;

    // Both request at reset exit: data first, then alternate.
    rst_n      = 1'b1;
    mem_rsp_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("rr_addr", mem_if.request_address, (c % 2 == 0) ? 32'h2000 : 32'h1000);
      chk("rr_data_ready", data_if.request_ready, (c % 2 == 0));
      chk("rr_inst_ready", inst_if.request_ready, (c % 2 != 0));
      advance();
    end
    drain();

    // Stalled inst request keeps its grant; data waits until it is accepted.
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'h3000;
    mem_if.request_ready    = 1'b0;
    settle();
    chk("hold_addr0", mem_if.request_address, 32'h3000);
    chk("hold_valid0", mem_if.request_valid, 1);
    advance();
    data_if.request_valid   = 1'b1;
    data_if.request_address = 32'h4000;
    for (int c = 1; c < 3; c++) begin
      settle();
      chk("hold_addr", mem_if.request_address, 32'h3000);
      chk("hold_data_ready", data_if.request_ready, 0);
      chk("hold_inst_ready", inst_if.request_ready, 0);
      advance();
    end
    mem_if.request_ready = 1'b1;
    settle();
    chk("hold_addr3", mem_if.request_address, 32'h3000);
    chk("hold_inst_acc", inst_if.request_ready, 1);
    chk("hold_data_wait", data_if.request_ready, 0);
    advance();
    inst_if.request_valid = 1'b0;
    settle();
    chk("hold_data_addr", mem_if.request_address, 32'h4000);
    chk("hold_data_acc", data_if.request_ready, 1);
    advance();
    drain();

    // Two outstanding fill the FIFO; third issues only after a pop.
    mem_rsp_en              = 1'b0;
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'h5000;
    data_if.request_valid   = 1'b1;
    data_if.request_address = 32'h6000;
    settle();
    chk("full_inst_acc", inst_if.request_ready, 1);
    advance();
    inst_if.request_valid = 1'b0;
    settle();
    chk("full_data_acc", data_if.request_ready, 1);
    advance();
    data_if.request_valid   = 1'b0;
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'h5100;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("full_stall_valid", mem_if.request_valid, 0);
      chk("full_stall_ready", inst_if.request_ready, 0);
      advance();
    end
    mem_rsp_en = 1'b1;
    settle();
    chk("full_pop_rsp", inst_if.response_valid, 1);
    chk("full_pop_no_bypass", mem_if.request_valid, 0);
    chk("full_pop_ready", inst_if.request_ready, 0);
    advance();
    mem_rsp_en = 1'b0;
    settle();
    chk("full_next_ready", inst_if.request_ready, 1);
    chk("full_next_valid", mem_if.request_valid, 1);
    chk("full_next_addr", mem_if.request_address, 32'h5100);
    advance();
    drain();

    // In-order routing of two reads with distinct data.
    mem_rsp_en              = 1'b0;
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'h100;
    settle();
    chk("ord_inst_acc", inst_if.request_ready, 1);
    advance();
    inst_if.request_valid   = 1'b0;
    data_if.request_valid   = 1'b1;
    data_if.request_address = 32'h200;
    settle();
    chk("ord_data_acc", data_if.request_ready, 1);
    advance();
    data_if.request_valid = 1'b0;
    mem_rsp_en            = 1'b1;
    settle();
    chk("ord_inst_valid", inst_if.response_valid, 1);
    chk("ord_inst_data", inst_if.response_read_data, 32'h0000_AAAA);
    chk("ord_data_quiet", data_if.response_valid, 0);
    advance();
    settle();
    chk("ord_data_valid", data_if.response_valid, 1);
    chk("ord_data_data", data_if.response_read_data, 32'h0000_BBBB);
    chk("ord_inst_quiet", inst_if.response_valid, 0);
    advance();
    drain();

    // Head requester back-pressure holds the response.
    mem_rsp_en              = 1'b0;
    data_if.request_valid   = 1'b1;
    data_if.request_address = 32'h7000;
    settle();
    chk("bp_data_acc", data_if.request_ready, 1);
    advance();
    data_if.request_valid  = 1'b0;
    data_if.response_ready = 1'b0;
    mem_rsp_en             = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("bp_mem_ready", mem_if.response_ready, 0);
      chk("bp_rsp_valid", data_if.response_valid, 1);
      chk("bp_rsp_data", data_if.response_read_data, rsp_of(32'h7000));
      advance();
    end
    data_if.response_ready = 1'b1;
    settle();
    chk("bp_mem_ready_rel", mem_if.response_ready, 1);
    advance();
    chk("bp_count", dut.u_id_fifo.count_q, 0);
    drain();

    // Reset with two outstanding; late responses are ignored.
    mem_rsp_en              = 1'b0;
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'h8000;
    data_if.request_valid   = 1'b1;
    data_if.request_address = 32'h9000;
    settle();
    chk("mr_inst_acc", inst_if.request_ready, 1);
    advance();
    inst_if.request_valid = 1'b0;
    settle();
    chk("mr_data_acc", data_if.request_ready, 1);
    advance();
    data_if.request_valid = 1'b0;
    chk("mr_count_full", dut.u_id_fifo.count_q, 2);
    rst_n = 1'b0;
    settle();
    chk("mr_rst_rsp_ready", mem_if.response_ready, 0);
    advance();
    step();
    chk("mr_count_rst", dut.u_id_fifo.count_q, 0);
    sb.delete();
    rst_n      = 1'b1;
    mem_rsp_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("late_inst_valid", inst_if.response_valid, 0);
      chk("late_data_valid", data_if.response_valid, 0);
      chk("late_mem_ready", mem_if.response_ready, 0);
      chk("late_count", dut.u_id_fifo.count_q, 0);
      advance();
    end
    mem_pend.delete();
    mem_rsp_en              = 1'b0;
    inst_if.request_valid   = 1'b1;
    inst_if.request_address = 32'hA000;
    settle();
    chk("post_rst_acc", inst_if.request_ready, 1);
    advance();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
